// File: rtl/bram_arb_pkg.sv
// Shared types and constants for the two-requester BRAM port arbiter.
package bram_arb_pkg;

  localparam int unsigned BRAM_AW         = 14;
  localparam int unsigned BRAM_DW         = 32;
  localparam int unsigned BRAM_ADDR_PAD   = 16;
  localparam int unsigned BRAM_BYTE_SHIFT = 2;

  typedef enum logic {
    ReqHost = 1'b0,
    ReqMul  = 1'b1
  } req_id_t;

  typedef struct packed {
    logic [BRAM_AW-1:0] addr;
    logic [BRAM_DW-1:0] wdata;
    logic [3:0]         be;
  } bram_req_t;

  // Word address to the 32-bit byte address seen on the BRAM pins.
  function automatic logic [31:0] byte_addr(input logic [BRAM_AW-1:0] addr);
    return {{BRAM_ADDR_PAD{1'b0}}, addr, {BRAM_BYTE_SHIFT{1'b0}}};
  endfunction

endpackage

// File: rtl/bram_rd_tag_pipe.sv
// Shift register of {valid, owner} tags that tracks reads in flight through the BRAM.
module bram_rd_tag_pipe #(
  parameter int unsigned Depth = 2
) (
  input  logic clk_i,
  input  logic clr_i,
  input  logic push_valid_i,
  input  logic push_owner_i,
  output logic out_valid_o,
  output logic out_owner_o
);

  logic [Depth-1:0] valid_d, valid_q;
  logic [Depth-1:0] owner_d, owner_q;

  always_comb begin
    valid_d = {valid_q[Depth-2:0], push_valid_i};
    owner_d = {owner_q[Depth-2:0], push_owner_i & push_valid_i};
  end

  always_ff @(posedge clk_i) begin
    if (clr_i) begin
      valid_q <= '0;
      owner_q <= '0;
    end else begin
      valid_q <= valid_d;
      owner_q <= owner_d;
    end
  end

  assign out_valid_o = valid_q[Depth-1];
  assign out_owner_o = owner_q[Depth-1];

endmodule

// File: rtl/bram_port_arbiter.sv
// Round-robin arbiter sharing one BRAM initiator port between the host path (r0) and the
// multiplier path (r1); registered BRAM outputs, read data returned to the issuing requester.
module bram_port_arbiter
  import bram_arb_pkg::*;
#(
  parameter int unsigned READ_LAT = 1,
  parameter int unsigned AW       = BRAM_AW,
  parameter int unsigned DW       = BRAM_DW
) (
  input  logic          CLK,
  input  logic          RST,
  input  logic          r0_req_valid,
  output logic          r0_req_ready,
  input  logic [AW-1:0] r0_req_addr,
  input  logic [DW-1:0] r0_req_wdata,
  input  logic [3:0]    r0_req_be,
  output logic          r0_rsp_valid,
  output logic [DW-1:0] r0_rsp_data,
  input  logic          r1_req_valid,
  output logic          r1_req_ready,
  input  logic [AW-1:0] r1_req_addr,
  input  logic [DW-1:0] r1_req_wdata,
  input  logic [3:0]    r1_req_be,
  output logic          r1_rsp_valid,
  output logic [DW-1:0] r1_rsp_data,
  output logic [31:0]   bramInitiatorWires_bramAddr,
  output logic [DW-1:0] bramInitiatorWires_bramDout,
  output logic [3:0]    bramInitiatorWires_bramWEN,
  output logic          bramInitiatorWires_bramEN,
  output logic          bramInitiatorWires_bramCLK,
  output logic          bramInitiatorWires_bramRST,
  input  logic [DW-1:0] bramInitiatorWires_bramDin
);

  logic      gnt0, gnt1, accept, tag_push;
  bram_req_t sel_req;
  req_id_t   last_grant_d, last_grant_q;

  logic [31:0]   bram_addr_d, bram_addr_q;
  logic [DW-1:0] bram_dout_d, bram_dout_q;
  logic [3:0]    bram_wen_d, bram_wen_q;
  logic          bram_en_d, bram_en_q;

  logic          tag_valid, tag_owner;
  logic          r0_rsp_valid_d, r0_rsp_valid_q, r1_rsp_valid_d, r1_rsp_valid_q;
  logic [DW-1:0] r0_rsp_data_d, r0_rsp_data_q, r1_rsp_data_d, r1_rsp_data_q;

  always_comb begin
    // On contention the requester that did not win last is preferred.
    gnt0   = r0_req_valid & (~r1_req_valid | (last_grant_q == ReqMul));
    gnt1   = r1_req_valid & (~r0_req_valid | (last_grant_q == ReqHost));
    accept = gnt0 | gnt1;

    if (gnt1) begin
      sel_req.addr  = BRAM_AW'(r1_req_addr);
      sel_req.wdata = BRAM_DW'(r1_req_wdata);
      sel_req.be    = r1_req_be;
    end else begin
      sel_req.addr  = BRAM_AW'(r0_req_addr);
      sel_req.wdata = BRAM_DW'(r0_req_wdata);
      sel_req.be    = r0_req_be;
    end

    tag_push     = accept & (sel_req.be == 4'h0);
    last_grant_d = last_grant_q;
    bram_addr_d  = bram_addr_q;
    bram_dout_d  = bram_dout_q;
    bram_wen_d   = 4'h0;
    bram_en_d    = accept;
    if (accept) begin
      last_grant_d = gnt1 ? ReqMul : ReqHost;
      bram_addr_d  = byte_addr(sel_req.addr);
      bram_dout_d  = DW'(sel_req.wdata);
      bram_wen_d   = sel_req.be;
    end

    r0_rsp_valid_d = tag_valid & ~tag_owner;
    r1_rsp_valid_d = tag_valid & tag_owner;
    r0_rsp_data_d  = r0_rsp_valid_d ? bramInitiatorWires_bramDin : r0_rsp_data_q;
    r1_rsp_data_d  = r1_rsp_valid_d ? bramInitiatorWires_bramDin : r1_rsp_data_q;
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      last_grant_q   <= ReqMul;
      bram_addr_q    <= '0;
      bram_dout_q    <= '0;
      bram_wen_q     <= '0;
      bram_en_q      <= 1'b0;
      r0_rsp_valid_q <= 1'b0;
      r1_rsp_valid_q <= 1'b0;
      r0_rsp_data_q  <= '0;
      r1_rsp_data_q  <= '0;
    end else begin
      last_grant_q   <= last_grant_d;
      bram_addr_q    <= bram_addr_d;
      bram_dout_q    <= bram_dout_d;
      bram_wen_q     <= bram_wen_d;
      bram_en_q      <= bram_en_d;
      r0_rsp_valid_q <= r0_rsp_valid_d;
      r1_rsp_valid_q <= r1_rsp_valid_d;
      r0_rsp_data_q  <= r0_rsp_data_d;
      r1_rsp_data_q  <= r1_rsp_data_d;
    end
  end

  // The tag reaches the last stage in the cycle bramDin carries that read's data.
  bram_rd_tag_pipe #(
    .Depth(READ_LAT + 1)
  ) u_tag_pipe (
    .clk_i       (CLK),
    .clr_i       (RST),
    .push_valid_i(tag_push),
    .push_owner_i(gnt1),
    .out_valid_o (tag_valid),
    .out_owner_o (tag_owner)
  );

  assign r0_req_ready = gnt0;
  assign r1_req_ready = gnt1;
  assign r0_rsp_valid = r0_rsp_valid_q;
  assign r1_rsp_valid = r1_rsp_valid_q;
  assign r0_rsp_data  = r0_rsp_data_q;
  assign r1_rsp_data  = r1_rsp_data_q;

  assign bramInitiatorWires_bramAddr = bram_addr_q;
  assign bramInitiatorWires_bramDout = bram_dout_q;
  assign bramInitiatorWires_bramWEN  = bram_wen_q;
  assign bramInitiatorWires_bramEN   = bram_en_q;
  assign bramInitiatorWires_bramCLK  = CLK;
  assign bramInitiatorWires_bramRST  = RST;

endmodule

// File: tb/tb_bram_port_arbiter.sv
// Bench for bram_port_arbiter: directed scenarios plus randomized traffic against a
// transaction-level reference model (READ_LAT=1), and a READ_LAT=2 instance.
module tb_bram_port_arbiter;

  logic clk;
  logic RST;
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // READ_LAT = 1 instance
  logic        r0_req_valid, r0_req_ready, r0_rsp_valid;
  logic [13:0] r0_req_addr;
  logic [31:0] r0_req_wdata, r0_rsp_data;
  logic [3:0]  r0_req_be;
  logic        r1_req_valid, r1_req_ready, r1_rsp_valid;
  logic [13:0] r1_req_addr;
  logic [31:0] r1_req_wdata, r1_rsp_data;
  logic [3:0]  r1_req_be;
  logic [31:0] bram_addr, bram_dout, bram_din;
  logic [3:0]  bram_wen;
  logic        bram_en, bram_clk, bram_rst;

  // READ_LAT = 2 instance, only r1 is exercised
  logic        b_r1_req_valid, b_r0_req_ready, b_r1_req_ready, b_r0_rsp_valid, b_r1_rsp_valid;
  logic [13:0] b_r1_req_addr;
  logic [31:0] b_r0_rsp_data, b_r1_rsp_data, b_bram_addr, b_bram_dout, b_bram_din, b_q1;
  logic [3:0]  b_bram_wen;
  logic        b_bram_en, b_bram_clk, b_bram_rst;

  int n_checks = 0;
  int n_pass   = 0;

  bram_port_arbiter #(.READ_LAT(1)) dut (
    .CLK(clk), .RST(RST),
    .r0_req_valid(r0_req_valid), .r0_req_ready(r0_req_ready), .r0_req_addr(r0_req_addr),
    .r0_req_wdata(r0_req_wdata), .r0_req_be(r0_req_be), .r0_rsp_valid(r0_rsp_valid),
    .r0_rsp_data(r0_rsp_data),
    .r1_req_valid(r1_req_valid), .r1_req_ready(r1_req_ready), .r1_req_addr(r1_req_addr),
    .r1_req_wdata(r1_req_wdata), .r1_req_be(r1_req_be), .r1_rsp_valid(r1_rsp_valid),
    .r1_rsp_data(r1_rsp_data),
    .bramInitiatorWires_bramAddr(bram_addr), .bramInitiatorWires_bramDout(bram_dout),
    .bramInitiatorWires_bramWEN(bram_wen), .bramInitiatorWires_bramEN(bram_en),
    .bramInitiatorWires_bramCLK(bram_clk), .bramInitiatorWires_bramRST(bram_rst),
    .bramInitiatorWires_bramDin(bram_din)
  );

  bram_port_arbiter #(.READ_LAT(2)) dut2 (
    .CLK(clk), .RST(RST),
    .r0_req_valid(1'b0), .r0_req_ready(b_r0_req_ready), .r0_req_addr(14'h0),
    .r0_req_wdata(32'h0), .r0_req_be(4'h0), .r0_rsp_valid(b_r0_rsp_valid),
    .r0_rsp_data(b_r0_rsp_data),
    .r1_req_valid(b_r1_req_valid), .r1_req_ready(b_r1_req_ready), .r1_req_addr(b_r1_req_addr),
    .r1_req_wdata(32'h0), .r1_req_be(4'h0), .r1_rsp_valid(b_r1_rsp_valid),
    .r1_rsp_data(b_r1_rsp_data),
    .bramInitiatorWires_bramAddr(b_bram_addr), .bramInitiatorWires_bramDout(b_bram_dout),
    .bramInitiatorWires_bramWEN(b_bram_wen), .bramInitiatorWires_bramEN(b_bram_en),
    .bramInitiatorWires_bramCLK(b_bram_clk), .bramInitiatorWires_bramRST(b_bram_rst),
    .bramInitiatorWires_bramDin(b_bram_din)
  );

  function automatic logic [31:0] init_word(input int i);
    if (i == 5) return 32'hDEADBEEF;
    return (32'(i) * 32'h9E3779B1) ^ 32'h5A5A0000;
  endfunction

  // BRAM models: one-cycle read latency for dut, two-cycle for dut2 (read-only).
  logic [31:0] mem1 [0:16383];
  logic        mem_init;
  always @(posedge clk) begin
    logic [31:0] w;
    if (mem_init) begin
      for (int i = 0; i < 16384; i++) mem1[i] <= init_word(i);
    end else if (bram_en) begin
      w = mem1[bram_addr[15:2]];
      for (int b = 0; b < 4; b++) if (bram_wen[b]) w[8*b +: 8] = bram_dout[8*b +: 8];
      mem1[bram_addr[15:2]] <= w;
      bram_din <= mem1[bram_addr[15:2]];
    end
  end

  always @(posedge clk) begin
    if (b_bram_en) b_q1 <= init_word(int'(b_bram_addr[15:2]));
    b_bram_din <= b_q1;
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    r0_req_valid = 0; r0_req_addr = '0; r0_req_wdata = '0; r0_req_be = '0;
    r1_req_valid = 0; r1_req_addr = '0; r1_req_wdata = '0; r1_req_be = '0;
    b_r1_req_valid = 0; b_r1_req_addr = '0;
  endtask

  task automatic apply_reset();
    idle();
    RST = 1'b1;
    tick();
    RST = 1'b0;
  endtask

  task automatic test_reset();
    idle();
    RST = 1'b1;
    tick();
    tick();
    @(negedge clk);
    n_checks++; if (bram_en !== 1'b0) $display("FAIL rst_en got %b want 0", bram_en); else n_pass++;
    n_checks++; if (bram_wen !== 4'h0) $display("FAIL rst_wen got %h want 0", bram_wen); else n_pass++;
    n_checks++; if (bram_addr !== 32'h0) $display("FAIL rst_addr got %h want 0", bram_addr);
    else n_pass++;
    n_checks++; if (bram_dout !== 32'h0) $display("FAIL rst_dout got %h want 0", bram_dout);
    else n_pass++;
    n_checks++; if ({r0_rsp_valid, r1_rsp_valid} !== 2'b00)
      $display("FAIL rst_rsp_valid got %b want 00", {r0_rsp_valid, r1_rsp_valid}); else n_pass++;
    n_checks++; if ({r0_rsp_data, r1_rsp_data} !== 64'h0)
      $display("FAIL rst_rsp_data got %h %h want 0", r0_rsp_data, r1_rsp_data); else n_pass++;
    n_checks++; if ({bram_rst, bram_clk} !== 2'b10)
      $display("FAIL rst_pins got rst=%b clk=%b want rst=1 clk=0", bram_rst, bram_clk);
    else n_pass++;
    n_checks++; if ({r0_req_ready, r1_req_ready, b_bram_en} !== 3'b000)
      $display("FAIL rst_idle_ready got %b want 000", {r0_req_ready, r1_req_ready, b_bram_en});
    else n_pass++;
    @(posedge clk); #1;
    RST = 1'b0;
  endtask

  task automatic test_single_read();
    apply_reset();
    r0_req_valid = 1; r0_req_addr = 14'h0005; r0_req_be = 4'h0;
    @(negedge clk);
    n_checks++; if ({r0_req_ready, r1_req_ready} !== 2'b10)
      $display("FAIL sr_ready got %b want 10", {r0_req_ready, r1_req_ready}); else n_pass++;
    tick(); idle();
    @(negedge clk);
    n_checks++; if ({bram_en, bram_addr, bram_wen} !== {1'b1, 32'h14, 4'h0})
      $display("FAIL sr_issue got en=%b addr=%h wen=%h want 1 00000014 0", bram_en, bram_addr,
               bram_wen); else n_pass++;
    for (int c = 2; c <= 4; c++) begin
      tick();
      @(negedge clk);
      n_checks++; if ({r0_rsp_valid, r1_rsp_valid} !== {c == 3, 1'b0})
        $display("FAIL sr_rsp_valid t+%0d got %b want %b", c, {r0_rsp_valid, r1_rsp_valid},
                 {c == 3, 1'b0}); else n_pass++;
      if (c == 3) begin
        n_checks++; if (r0_rsp_data !== 32'hDEADBEEF)
          $display("FAIL sr_rsp_data got %h want deadbeef", r0_rsp_data); else n_pass++;
      end
    end
    tick();
  endtask

  task automatic test_write_read();
    apply_reset();
    r1_req_valid = 1; r1_req_addr = 14'h0100; r1_req_wdata = 32'h12345678; r1_req_be = 4'hF;
    @(negedge clk);
    n_checks++; if (r1_req_ready !== 1'b1) $display("FAIL wr_ready got %b want 1", r1_req_ready);
    else n_pass++;
    tick();
    r1_req_wdata = 32'h0; r1_req_be = 4'h0;
    @(negedge clk);
    n_checks++; if ({bram_en, bram_wen, bram_dout} !== {1'b1, 4'hF, 32'h12345678})
      $display("FAIL wr_issue got en=%b wen=%h dout=%h want 1 f 12345678", bram_en, bram_wen,
               bram_dout); else n_pass++;
    tick(); idle();
    @(negedge clk);
    n_checks++; if ({bram_en, bram_wen, bram_addr} !== {1'b1, 4'h0, 32'h400})
      $display("FAIL rd_issue got en=%b wen=%h addr=%h want 1 0 00000400", bram_en, bram_wen,
               bram_addr); else n_pass++;
    for (int c = 3; c <= 5; c++) begin
      tick();
      @(negedge clk);
      n_checks++; if ({r0_rsp_valid, r1_rsp_valid} !== {1'b0, c == 4})
        $display("FAIL wr_rsp_valid t+%0d got %b want %b", c, {r0_rsp_valid, r1_rsp_valid},
                 {1'b0, c == 4}); else n_pass++;
      if (c == 4) begin
        n_checks++; if (r1_rsp_data !== 32'h12345678)
          $display("FAIL wr_rsp_data got %h want 12345678", r1_rsp_data); else n_pass++;
      end
    end
    tick();
  endtask

  task automatic test_contention();
    logic [31:0] exp0[$], exp1[$];
    int a0 = 0, a1 = 0, got0 = 0, got1 = 0;
    apply_reset();
    for (int c = 0; c < 12; c++) begin
      if (c < 6) begin
        r0_req_valid = 1; r0_req_addr = 14'(16'h10 + a0); r0_req_be = 4'h0;
        r1_req_valid = 1; r1_req_addr = 14'(16'h20 + a1); r1_req_be = 4'h0;
      end else idle();
      @(negedge clk);
      if (c < 6) begin
        n_checks++; if ({r0_req_ready, r1_req_ready} !== {c % 2 == 0, c % 2 == 1})
          $display("FAIL cont_grant c%0d got %b want %b", c, {r0_req_ready, r1_req_ready},
                   {c % 2 == 0, c % 2 == 1}); else n_pass++;
        if (c % 2 == 0) begin exp0.push_back(init_word(16'h10 + a0)); a0++; end
        else begin exp1.push_back(init_word(16'h20 + a1)); a1++; end
      end
      if (r0_rsp_valid) begin
        got0++;
        n_checks++;
        if (exp0.size() == 0) $display("FAIL cont_rsp0 got %h want none", r0_rsp_data);
        else if (r0_rsp_data !== exp0[0])
          $display("FAIL cont_rsp0 got %h want %h", r0_rsp_data, exp0[0]);
        else n_pass++;
        if (exp0.size() != 0) void'(exp0.pop_front());
      end
      if (r1_rsp_valid) begin
        got1++;
        n_checks++;
        if (exp1.size() == 0) $display("FAIL cont_rsp1 got %h want none", r1_rsp_data);
        else if (r1_rsp_data !== exp1[0])
          $display("FAIL cont_rsp1 got %h want %h", r1_rsp_data, exp1[0]);
        else n_pass++;
        if (exp1.size() != 0) void'(exp1.pop_front());
      end
      tick();
    end
    n_checks++; if (got0 != 3 || got1 != 3)
      $display("FAIL cont_rsp_count got %0d,%0d want 3,3", got0, got1); else n_pass++;
  endtask

  task automatic test_partial_write();
    apply_reset();
    r0_req_valid = 1; r0_req_addr = 14'h0030; r0_req_wdata = 32'h00AB0000; r0_req_be = 4'b0100;
    @(negedge clk);
    n_checks++; if (r0_req_ready !== 1'b1) $display("FAIL pw_ready got %b want 1", r0_req_ready);
    else n_pass++;
    tick(); idle();
    @(negedge clk);
    n_checks++; if ({bram_en, bram_wen, bram_dout} !== {1'b1, 4'b0100, 32'h00AB0000})
      $display("FAIL pw_issue got en=%b wen=%b dout=%h want 1 0100 00ab0000", bram_en,
               bram_wen, bram_dout); else n_pass++;
    for (int c = 2; c <= 5; c++) begin
      tick();
      @(negedge clk);
      n_checks++; if ({bram_en, bram_wen, r0_rsp_valid, r1_rsp_valid} !== 7'h0)
        $display("FAIL pw_quiet t+%0d got en=%b wen=%b rsp=%b%b want all 0", c, bram_en,
                 bram_wen, r0_rsp_valid, r1_rsp_valid); else n_pass++;
    end
    tick();
  endtask

  task automatic test_reset_midflight();
    apply_reset();
    r0_req_valid = 1; r0_req_addr = 14'h0005; r0_req_be = 4'h0;
    @(negedge clk);
    n_checks++; if (r0_req_ready !== 1'b1) $display("FAIL rm_ready got %b want 1", r0_req_ready);
    else n_pass++;
    tick(); idle();
    RST = 1'b1;
    tick();
    RST = 1'b0;
    @(negedge clk);
    n_checks++; if (bram_en !== 1'b0) $display("FAIL rm_en got %b want 0", bram_en); else n_pass++;
    for (int c = 0; c < 4; c++) begin
      n_checks++; if (r0_rsp_valid !== 1'b0)
        $display("FAIL rm_no_rsp c%0d got %b want 0", c, r0_rsp_valid); else n_pass++;
      tick();
      @(negedge clk);
    end
    @(posedge clk); #1;
    r0_req_valid = 1; r0_req_be = 4'h1; r1_req_valid = 1; r1_req_be = 4'h1;
    @(negedge clk);
    n_checks++; if ({r0_req_ready, r1_req_ready} !== 2'b10)
      $display("FAIL rm_first_grant got %b want 10", {r0_req_ready, r1_req_ready}); else n_pass++;
    tick(); idle();
  endtask

  task automatic test_read_lat2();
    apply_reset();
    b_r1_req_valid = 1; b_r1_req_addr = 14'h0007;
    @(negedge clk);
    n_checks++; if ({b_r0_req_ready, b_r1_req_ready} !== 2'b01)
      $display("FAIL l2_ready got %b want 01", {b_r0_req_ready, b_r1_req_ready}); else n_pass++;
    tick(); idle();
    for (int c = 1; c <= 5; c++) begin
      @(negedge clk);
      if (c == 1) begin
        n_checks++; if ({b_bram_en, b_bram_addr, b_bram_wen, b_bram_dout} !== {1'b1, 32'h1C, 36'h0})
          $display("FAIL l2_issue got en=%b addr=%h want 1 0000001c", b_bram_en, b_bram_addr);
        else n_pass++;
      end
      n_checks++; if ({b_r0_rsp_valid, b_r1_rsp_valid} !== {1'b0, c == 4})
        $display("FAIL l2_rsp_valid t+%0d got %b want %b", c, {b_r0_rsp_valid, b_r1_rsp_valid},
                 {1'b0, c == 4}); else n_pass++;
      if (c == 4) begin
        n_checks++; if ({b_r1_rsp_data, b_r0_rsp_data} !== {init_word(7), 32'h0})
          $display("FAIL l2_rsp_data got %h want %h", b_r1_rsp_data, init_word(7)); else n_pass++;
      end
      @(posedge clk); #1;
    end
    n_checks++; if ({b_bram_rst, b_bram_clk} !== 2'b01)
      $display("FAIL l2_pins got rst=%b clk=%b want 0 1", b_bram_rst, b_bram_clk); else n_pass++;
  endtask

  // Transaction-level model: grant by the round-robin rule, a word memory for expected
  // read data, and per-requester queues of (due cycle, data).
  task automatic test_random();
    localparam int N = 300;
    logic [31:0] ref_mem [int];
    int          due0[$], due1[$];
    logic [31:0] dat0[$], dat1[$];
    logic        m_last, g0, g1, acc0, acc1, exp_en, e0, e1;
    logic [3:0]  exp_wen, s_be;
    logic [31:0] exp_addr, exp_dout, s_wd, w;
    int          s_a;
    mem_init = 1'b1;
    tick();
    mem_init = 1'b0;
    apply_reset();
    m_last = 1; acc0 = 0; acc1 = 0; exp_en = 0; exp_wen = 0; exp_addr = 0; exp_dout = 0;
    for (int k = 0; k < N + 8; k++) begin
      if (r0_req_valid && !acc0) begin
        if (k >= N || $urandom_range(0, 4) == 0) r0_req_valid = 0;
      end else begin
        r0_req_valid = (k < N) && ($urandom_range(0, 1) == 1);
        r0_req_addr  = 14'(16'h200 + $urandom_range(0, 7));
        r0_req_wdata = $urandom;
        r0_req_be    = ($urandom_range(0, 1) == 0) ? 4'h0 : 4'($urandom_range(1, 15));
      end
      if (r1_req_valid && !acc1) begin
        if (k >= N || $urandom_range(0, 4) == 0) r1_req_valid = 0;
      end else begin
        r1_req_valid = (k < N) && ($urandom_range(0, 1) == 1);
        r1_req_addr  = 14'(16'h200 + $urandom_range(0, 7));
        r1_req_wdata = $urandom;
        r1_req_be    = ($urandom_range(0, 1) == 0) ? 4'h0 : 4'($urandom_range(1, 15));
      end
      @(negedge clk);
      g0 = r0_req_valid && (!r1_req_valid || m_last);
      g1 = r1_req_valid && (!r0_req_valid || !m_last);
      n_checks++; if ({r0_req_ready, r1_req_ready} !== {g0, g1})
        $display("FAIL rnd_grant k%0d got %b want %b", k, {r0_req_ready, r1_req_ready}, {g0, g1});
      else n_pass++;
      n_checks++; if ({bram_en, bram_wen, bram_addr, bram_dout} !==
                      {exp_en, exp_wen, exp_addr, exp_dout})
        $display("FAIL rnd_issue k%0d got %b %h %h %h want %b %h %h %h", k, bram_en, bram_wen,
                 bram_addr, bram_dout, exp_en, exp_wen, exp_addr, exp_dout);
      else n_pass++;
      e0 = (due0.size() > 0) && (due0[0] == k);
      e1 = (due1.size() > 0) && (due1[0] == k);
      n_checks++; if ({r0_rsp_valid, r1_rsp_valid} !== {e0, e1})
        $display("FAIL rnd_rsp_valid k%0d got %b want %b", k, {r0_rsp_valid, r1_rsp_valid},
                 {e0, e1}); else n_pass++;
      if (e0) begin
        n_checks++; if (r0_rsp_data !== dat0[0])
          $display("FAIL rnd_rsp0 k%0d got %h want %h", k, r0_rsp_data, dat0[0]); else n_pass++;
        void'(due0.pop_front()); void'(dat0.pop_front());
      end
      if (e1) begin
        n_checks++; if (r1_rsp_data !== dat1[0])
          $display("FAIL rnd_rsp1 k%0d got %h want %h", k, r1_rsp_data, dat1[0]); else n_pass++;
        void'(due1.pop_front()); void'(dat1.pop_front());
      end
      exp_en = g0 | g1;
      exp_wen = 4'h0;
      if (g0 | g1) begin
        m_last = g1;
        s_a  = g1 ? int'(r1_req_addr) : int'(r0_req_addr);
        s_wd = g1 ? r1_req_wdata : r0_req_wdata;
        s_be = g1 ? r1_req_be : r0_req_be;
        w = ref_mem.exists(s_a) ? ref_mem[s_a] : init_word(s_a);
        exp_wen = s_be; exp_addr = 32'(s_a) * 4; exp_dout = s_wd;
        if (s_be == 4'h0) begin
          if (g1) begin due1.push_back(k + 3); dat1.push_back(w); end
          else begin due0.push_back(k + 3); dat0.push_back(w); end
        end else begin
          for (int b = 0; b < 4; b++) if (s_be[b]) w[8*b +: 8] = s_wd[8*b +: 8];
          ref_mem[s_a] = w;
        end
      end
      acc0 = g0; acc1 = g1;
      @(posedge clk); #1;
    end
    n_checks++; if (due0.size() + due1.size() != 0)
      $display("FAIL rnd_drain got %0d outstanding want 0", due0.size() + due1.size());
    else n_pass++;
  endtask

  initial begin
    idle();
    RST = 1'b1;
    mem_init = 1'b1;
    tick();
    mem_init = 1'b0;
    test_reset();
    test_single_read();
    test_write_read();
    test_contention();
    test_partial_write();
    test_reset_midflight();
    test_read_lat2();
    test_random();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog time limit reached");
    $fatal(1, "timeout");
  end

endmodule
